// File: rtl/nt_chain_detector.sv
// Tapped A/B shift chains plus C stage into per-lane dout = A_t | B_t | ~C; din->dout latency tap+1 (C: 1).
// en=0 stalls all state. `define NT_ALARM_EN compiles in the saturating hit counter and sticky alarm.
module nt_chain_detector #(
    parameter  int W     = 4,
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 8,
    localparam int TAP_W = $clog2(DEPTH)
) (
    input  logic             I1294_clk,
    input  logic             I1301_rst,
    input  logic             en,
    input  logic             clr,
    input  logic [W-1:0]     din_a,
    input  logic [W-1:0]     din_b,
    input  logic [W-1:0]     din_c,
    input  logic [TAP_W-1:0] tap_a,
    input  logic [TAP_W-1:0] tap_b,
    input  logic             inv_b,
    input  logic [CNT_W-1:0] thresh,
    output logic [W-1:0]     dout,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             alarm
);

    logic [DEPTH-1:0][W-1:0] chain_a_q, chain_a_d;
    logic [DEPTH-1:0][W-1:0] chain_b_q, chain_b_d;
    logic [W-1:0]            stage_c_q, stage_c_d;
    logic [TAP_W-1:0]        sel_a, sel_b;
    logic [W-1:0]            a_t, b_t;

    always_comb begin
        chain_a_d = chain_a_q;
        chain_b_d = chain_b_q;
        stage_c_d = stage_c_q;
        if (en) begin
            chain_a_d = {chain_a_q[DEPTH-2:0], din_a};
            chain_b_d = {chain_b_q[DEPTH-2:0], din_b};
            stage_c_d = din_c;
        end
    end

    always_ff @(posedge I1294_clk) begin
        if (I1301_rst) begin
            chain_a_q <= '0;
            chain_b_q <= '0;
            stage_c_q <= '0;
        end else begin
            chain_a_q <= chain_a_d;
            chain_b_q <= chain_b_d;
            stage_c_q <= stage_c_d;
        end
    end

    // Taps beyond the last stage clamp to it when DEPTH is not a power of two.
    always_comb begin
        sel_a = tap_a;
        sel_b = tap_b;
        if (int'(tap_a) > DEPTH - 1) sel_a = TAP_W'(DEPTH - 1);
        if (int'(tap_b) > DEPTH - 1) sel_b = TAP_W'(DEPTH - 1);
    end

    assign a_t  = chain_a_q[sel_a];
    assign b_t  = chain_b_q[sel_b] ^ {W{inv_b}};
    assign dout = ~(~a_t & ~(b_t | ~stage_c_q));
    assign hit  = |(~dout);

`ifdef NT_ALARM_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             alarm_q, alarm_d;

    // clr beats a same-cycle increment; alarm compares the pre-edge count.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        alarm_d   = alarm_q;
        if (clr) begin
            hit_cnt_d = '0;
            alarm_d   = 1'b0;
        end else if (en) begin
            if (thresh != '0 && hit_cnt_q >= thresh) alarm_d = 1'b1;
            if (hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge I1294_clk) begin
        if (I1301_rst) begin
            hit_cnt_q <= '0;
            alarm_q   <= 1'b0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            alarm_q   <= alarm_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
    assign alarm   = alarm_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{clr, thresh};
    assign hit_cnt    = '0;
    assign alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_nt_chain_detector.sv
// Directed bench for nt_chain_detector with a reference model feeding an expected-result queue.
module tb_nt_chain_detector;
    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
`ifdef NT_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, en, clr, inv_b;
    logic [W-1:0]     din_a, din_b, din_c;
    logic [2:0]       tap_a, tap_b;
    logic [CNT_W-1:0] thresh;
    logic [W-1:0]     dout;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt;
    logic             alarm;

    always #5 clk = ~clk;

    nt_chain_detector #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .I1294_clk(clk), .I1301_rst(rst), .en(en), .clr(clr),
        .din_a(din_a), .din_b(din_b), .din_c(din_c),
        .tap_a(tap_a), .tap_b(tap_b), .inv_b(inv_b), .thresh(thresh),
        .dout(dout), .hit(hit), .hit_cnt(hit_cnt), .alarm(alarm)
    );

    typedef struct packed {
        logic [W-1:0]     dout;
        logic             hit;
        logic [CNT_W-1:0] cnt;
        logic             alarm;
    } obs_t;

    obs_t             sb_q[$];
    logic [W-1:0]     ma[DEPTH];
    logic [W-1:0]     mb[DEPTH];
    logic [W-1:0]     mc;
    logic [CNT_W-1:0] mcnt;
    logic             malarm;
    int               tests = 0;
    int               fails = 0;

    function automatic logic [W-1:0] m_dout();
        return ma[tap_a] | (mb[tap_b] ^ {W{inv_b}}) | ~mc;
    endfunction

    task automatic expect_now(input string tag);
        obs_t e, o;
        e.dout  = m_dout();
        e.hit   = |(~e.dout);
        e.cnt   = ALARM_ON ? mcnt : '0;
        e.alarm = ALARM_ON ? malarm : 1'b0;
        sb_q.push_back(e);
        o = {dout, hit, hit_cnt, alarm};
        e = sb_q.pop_front();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed dout=%h hit=%b cnt=%0d alarm=%b, expected dout=%h hit=%b cnt=%0d alarm=%b",
                   tag, o.dout, o.hit, o.cnt, o.alarm, e.dout, e.hit, e.cnt, e.alarm);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge: advance the model with the inputs present at the edge, then compare.
    task automatic step(input string tag);
        logic pre_hit;
        @(posedge clk);
        pre_hit = |(~m_dout());
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ma[k] = '0;
                mb[k] = '0;
            end
            mc     = '0;
            mcnt   = '0;
            malarm = 1'b0;
        end else begin
            if (clr) begin
                mcnt   = '0;
                malarm = 1'b0;
            end else if (en) begin
                if (thresh != 0 && mcnt >= thresh) malarm = 1'b1;
                if (pre_hit && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
            end
            if (en) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    ma[k] = ma[k-1];
                    mb[k] = mb[k-1];
                end
                ma[0] = din_a;
                mb[0] = din_b;
                mc    = din_c;
            end
        end
        #1;
        expect_now(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; inv_b = 1'b0;
        din_a = '0; din_b = '0; din_c = '0; tap_a = '0; tap_b = '0; thresh = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ma[k] = '0;
            mb[k] = '0;
        end
        mc = '0; mcnt = '0; malarm = 1'b0;

        step("rst0");
        step("rst1");
        check_val("rst_dout", 32'(dout), 32'hF);
        check_val("rst_hit", 32'(hit), 32'h0);
        check_val("rst_cnt", 32'(hit_cnt), 32'h0);
        check_val("rst_alarm", 32'(alarm), 32'h0);

        rst = 1'b0;
        din_c = 4'hF; din_b = '0; inv_b = 1'b0; tap_a = 3'd2; tap_b = '0; en = 1'b1; din_a = 4'h5;
        step("lat_e1");
        check_val("lat_e1_dout", 32'(dout), 32'h0);
        din_a = '0;
        step("lat_e2");
        check_val("lat_e2_dout", 32'(dout), 32'h0);
        step("lat_e3");
        check_val("lat_e3_dout", 32'(dout), 32'h5);
        step("lat_e4");
        check_val("lat_e4_dout", 32'(dout), 32'h0);

        tap_a = 3'd3;
        #1;
        expect_now("tap_live");
        check_val("tap_live_dout", 32'(dout), 32'h5);

        tap_a = 3'd0; din_a = 4'h9;
        step("invb0");
        check_val("invb0_dout", 32'(dout), 32'h9);
        inv_b = 1'b1; din_a = 4'h6;
        step("invb1");
        check_val("invb1_dout", 32'(dout), 32'hF);
        inv_b = 1'b0;

        din_c = 4'h0; din_a = 4'h3; din_b = 4'h6;
        step("c0");
        check_val("c0_dout", 32'(dout), 32'hF);
        check_val("c0_hit", 32'(hit), 32'h0);

        for (int i = 0; i < 24; i++) begin
            din_a = W'($urandom); din_b = W'($urandom); din_c = W'($urandom);
            tap_a = 3'($urandom); tap_b = 3'($urandom); inv_b = 1'($urandom);
            step("rand");
        end

        rst = 1'b1;
        step("rst_mid");
        check_val("rst_mid_dout", 32'(dout), 32'hF);
        rst = 1'b0; din_a = '0; din_b = '0; din_c = 4'hF; inv_b = 1'b0;
        tap_a = 3'd2; tap_b = 3'd5; thresh = 8'd3;
        step("cnt_e1");
        check_val("flush_dout", 32'(dout), 32'h0);
        check_val("cnt_e1", 32'(hit_cnt), 32'h0);
        step("cnt_e2");
        check_val("cnt_e2", 32'(hit_cnt), ALARM_ON ? 32'd1 : 32'd0);
        step("cnt_e3");
        check_val("cnt_e3", 32'(hit_cnt), ALARM_ON ? 32'd2 : 32'd0);
        step("cnt_e4");
        check_val("cnt_e4", 32'(hit_cnt), ALARM_ON ? 32'd3 : 32'd0);
        check_val("alarm_e4", 32'(alarm), 32'd0);
        step("cnt_e5");
        check_val("alarm_e5", 32'(alarm), ALARM_ON ? 32'd1 : 32'd0);
        thresh = 8'd200;
        step("thresh_chg");
        check_val("alarm_sticky", 32'(alarm), ALARM_ON ? 32'd1 : 32'd0);
        clr = 1'b1;
        step("clr");
        check_val("clr_cnt", 32'(hit_cnt), 32'd0);
        check_val("clr_alarm", 32'(alarm), 32'd0);
        clr = 1'b0; thresh = '0;
        for (int i = 0; i < 300; i++) step("sat");
        check_val("sat_cnt", 32'(hit_cnt), ALARM_ON ? 32'd255 : 32'd0);
        check_val("sat_alarm_off", 32'(alarm), 32'd0);

        rst = 1'b1;
        step("frz_rst");
        rst = 1'b0; tap_a = 3'd1; tap_b = '0; din_c = 4'hF;
        din_a = 4'h1; step("frz_d1");
        din_a = 4'h2; step("frz_d2");
        din_a = 4'h3; step("frz_d3");
        en = 1'b0; din_a = 4'hE;
        for (int i = 0; i < 4; i++) begin
            step("frz_hold");
            check_val("frz_dout", 32'(dout), 32'h2);
            check_val("frz_cnt", 32'(hit_cnt), ALARM_ON ? 32'd2 : 32'd0);
        end
        en = 1'b1;
        din_a = 4'h4; step("frz_r1");
        check_val("frz_r1_dout", 32'(dout), 32'h3);
        din_a = 4'h5; step("frz_r2");
        check_val("frz_r2_dout", 32'(dout), 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nt_chain_detector.md
NT_CHAIN_DETECTOR -- requirements
Module: nt_chain_detector

Interface
REQ-001 Parameter W, default 4: lane width of every data path; lanes are bitwise-independent.
REQ-002 Parameter DEPTH, default 8: maximum register-chain depth, range 2..16.
REQ-003 Parameter CNT_W, default 8: hit-counter and threshold width.
REQ-004 I1294_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 I1301_rst  input  1  reset; synchronous, active-high.
REQ-006 en  input  1  advance enable; 1 shifts all chains and counts hits, 0 holds all state.
REQ-007 clr  input  1  synchronous clear of hit counter and alarm.
REQ-008 din_a, din_b, din_c  input  W each  data into chains A, B and stage C.
REQ-009 tap_a, tap_b  input  $clog2(DEPTH) each  tap stage select for chains A and B.
REQ-010 inv_b  input  1  inverts the chain-B tap before combining.
REQ-011 thresh  input  CNT_W  alarm threshold; 0 disables the alarm.
REQ-012 dout  output  W  per-lane detector output.
REQ-013 hit  output  1  OR-reduce of ~dout.
REQ-014 hit_cnt  output  CNT_W  saturating hit count.
REQ-015 alarm  output  1  sticky threshold alarm.

Function
REQ-016 Chains A and B are DEPTH-stage W-bit shift registers; with en=1: stage0 <= din, stage k <= stage k-1.
REQ-017 Stage C is one W-bit register loading din_c when en=1.
REQ-018 A_t = chain A stage min(tap_a, DEPTH-1); B_t = chain B stage min(tap_b, DEPTH-1), XOR inv_b on every lane.
REQ-019 dout = ~( ~A_t & ~(B_t | ~C) ), bitwise and combinational from registered state; no output register.
REQ-020 Latency din_a -> dout = tap_a+1 en-cycles; din_b -> dout = tap_b+1; din_c -> dout = 1.
REQ-021 A tap change takes effect in the same cycle, with no flush and no glitch suppression beyond the combinational settling time.
REQ-022 With en=0, chains, C, hit_cnt and alarm hold; dout and hit follow the held state and live tap/inv_b.
REQ-023 hit_cnt increments by 1 on each edge with en=1 and hit=1; it saturates at 2^CNT_W-1 and never wraps.
REQ-024 alarm sets on an edge where hit_cnt >= thresh and thresh != 0; it stays set until clr or reset.
REQ-025 When clr and an increment occur in the same cycle, clr wins: hit_cnt <= 0 and alarm <= 0.
REQ-026 A thresh change after alarm is set does not clear alarm.

Reset
REQ-027 I1301_rst=1 at an edge zeroes all chain stages, C, hit_cnt and alarm, and overrides en and clr.
REQ-028 After reset, dout = all ones, hit = 0, hit_cnt = 0, alarm = 0.
REQ-029 Reset asserted mid-operation discards all in-flight chain data within one cycle.

Configuration
REQ-030 Macro NT_ALARM_EN defined: the hit counter and alarm logic of REQ-023..026 are compiled in.
REQ-031 Macro NT_ALARM_EN undefined: counter logic is absent and hit_cnt and alarm are tied to 0; ports, dout and hit are unchanged.

Verification
REQ-032 The bench covers the following directed scenarios with W=4, DEPTH=8 and NT_ALARM_EN defined:
- Reset held for 2 cycles -> dout=4'hF, hit=0, hit_cnt=0, alarm=0.
- din_c=4'hF, din_b=0, inv_b=0, tap_a=2, en=1, din_a=4'h5 for one cycle then 0 -> dout=4'h5 exactly 3 cycles later, otherwise 4'h0.
- din_c=4'h0, any din_a/din_b -> dout=4'hF and hit=0 from the cycle after C loads.
- din_c=4'hF, din_b=0, inv_b=1 -> dout=4'hF; with inv_b=0 -> dout equals A_t.
- thresh=3 with hit held high, en=1 -> hit_cnt counts 1,2,3 and alarm rises one edge after hit_cnt=3; clr then gives 0/0; 300 hit cycles saturate hit_cnt at 255.
- en=0 for 4 cycles mid-stream -> dout and hit_cnt frozen; on resume the data sequence continues unshifted.
